max_pool_ctrl: RTL and testbench
================================

# max_pool_ctrl

Streaming 2-D max-pooling sequencer for the MAX_POOL datapath. It accepts a raster-order pixel stream of an IMG_W x IMG_H feature map over a valid/ready handshake. It sequences a horizontal running-max accumulator and a one-row partial-max line buffer, and emits one pooled pixel per non-overlapping POOL x POOL window (stride = POOL) over a registered valid/ready output. It sits between the convolution output stream and the next layer's input.

## Interface
- BITWIDTH, 8: unsigned pixel width.
- IMG_W, 28: pixels per input row; must be a multiple of POOL (elaboration-time check).
- IMG_H, 28: rows per input frame; must be a multiple of POOL.
- POOL, 2: window edge and stride; range 2..4.
- clk  in  1  single clock; all logic is on its rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous soft restart: drops any partial frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_data  in  BITWIDTH  unsigned input pixel.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts the pooled pixel.
- out_data  out  BITWIDTH  pooled maximum.
- out_last  out  1  qualifies the final pooled pixel of a frame.
- frame_done  out  1  one-cycle pulse when the final pooled pixel of a frame is accepted.

## Operation
- Accept: a pixel is taken when in_valid && in_ready. in_ready = !clear && (!out_valid || out_ready).
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) advance per accepted pixel. col wraps to 0 and increments row. row wraps to 0 after the last pixel of the frame.
- Window position: cx = col % POOL, ry = row % POOL, g = col / POOL. Use sub-counters, not dividers.
- Horizontal accumulator hmax:
  - cx == 0: load the pixel.
  - Otherwise: hmax = max(hmax, pixel), unsigned compare.
- Window column complete (cx == POOL-1). Let h = max(hmax, pixel).
  - ry == 0: linebuf[g] = h.
  - 0 < ry < POOL-1: linebuf[g] = max(linebuf[g], h).
  - ry == POOL-1: out_data = max(linebuf[g], h); out_valid = 1; out_last = (row == IMG_H-1 && col == IMG_W-1).
- linebuf has IMG_W/POOL entries of BITWIDTH bits. It needs no reset because every entry is written at ry == 0 before it is read.
- Output holding: while out_valid && !out_ready, out_data and out_last are held stable and no pixel is accepted.
- Output release: when out_valid && out_ready and no new output is produced, out_valid drops to 0 next cycle. Back-to-back output (accept and produce in the same cycle) is allowed.
- frame_done asserts for one cycle in the cycle after out_valid && out_ready && out_last.
- clear:
  - Next cycle: col, row, cx, ry = 0; out_valid = 0; out_last = 0.
  - A pending output is discarded.
  - frame_done is not generated.
  - clear has priority over a simultaneous in_valid; that pixel is not accepted.

## Timing
- Reset values: in_ready 0 during reset and 1 after; out_valid 0, out_data 0, out_last 0, frame_done 0, all counters 0, hmax 0.
- Latency: out_valid rises in the cycle after the bottom-right pixel of a window is accepted.
- Throughput: one pixel per cycle with out_ready held high. Outputs total (IMG_W/POOL)*(IMG_H/POOL) per frame.
- Reset asserted mid-frame: all registers go to reset values immediately. The next accepted pixel is treated as (row 0, col 0).
- Frames are back-to-back: the first pixel of the next frame may be accepted in the cycle out_last is handed off.
- Equal values: the output equals the value; there is no tie ordering.

## Test plan
- Basic pooling (IMG_W = IMG_H = 4, POOL = 2). Send rows {1,5,2,0}, {3,4,9,8}, {7,7,0,0}, {6,2,1,255} with out_ready = 1.
  - Expect outputs 5, 9, 7, 255.
  - out_last on 255 only; frame_done one cycle after it.
- Backpressure: same frame, out_ready low for 3 cycles after each out_valid.
  - out_data stays stable and in_ready stays 0 while stalled.
  - No pixel is lost or duplicated; sequence is still 5, 9, 7, 255.
- Extremes: a frame of all 0, then all 255 (BITWIDTH 8).
  - Expect four 0s, then four 255s.
  - Confirms no stale linebuf or hmax carry-over across frames.
- Soft clear: assert clear after 6 pixels of a frame with in_valid high, then send a full frame.
  - The clear cycle pixel is not accepted.
  - Expect exactly 4 outputs matching the new frame; no frame_done for the aborted frame.
- Async reset mid-frame: drop rstn between clock edges while out_valid = 1.
  - out_valid, out_data and out_last go to 0 immediately.
  - A subsequent full frame pools correctly.
- POOL = 3, IMG_W = IMG_H = 6 with a ramp input (pixel = row*6 + col).
  - Expect outputs 14, 17, 32, 35.

Source files
------------

// File: rtl/max_pool_ctrl_if.sv
// Pixel-in / pooled-pixel-out bundle for max_pool_ctrl, plus soft clear and frame pulse.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
interface max_pool_ctrl_if #(
    parameter int BITWIDTH = 8
);
    logic                clear;
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [BITWIDTH-1:0] out_data;
    logic                out_last;
    logic                frame_done;

    // Pooling block side
    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, frame_done
    );

    // Stream source / sink side
    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, frame_done
    );
endinterface

// File: rtl/max_pool_ctrl.sv
// Streaming POOLxPOOL stride-POOL max-pooling over a raster IMG_W x IMG_H pixel stream.
// Latency: pooled pixel is valid the cycle after the window's bottom-right pixel is accepted.
// Backpressure: a held (unaccepted) output stalls input; clear drops the partial frame and any pending output.
module max_pool_ctrl #(
    parameter int BITWIDTH = 8,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int POOL     = 2
) (
    input  logic           clk,
    input  logic           rstn,
    max_pool_ctrl_if.slave bus
);
    localparam int NG = IMG_W / POOL;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = $clog2(POOL);
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [PW-1:0] WIN_LAST = PW'(POOL - 1);

    generate
        if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0 || POOL < 2 || POOL > 4) begin : g_bad_cfg
            $error("max_pool_ctrl: IMG_W/IMG_H must be multiples of POOL and POOL must be 2..4");
        end
    endgenerate

    function automatic logic [BITWIDTH-1:0] umax(input logic [BITWIDTH-1:0] a,
                                                 input logic [BITWIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Position counters; cx/ry/g shadow col%POOL, row%POOL, col/POOL without dividers.
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [PW-1:0]       r_cx;
    logic [PW-1:0]       r_ry;
    logic [GW-1:0]       r_g;
    logic [BITWIDTH-1:0] r_hmax;
    logic [BITWIDTH-1:0] r_lbuf [NG];

    logic                r_rdy_en;
    logic                r_out_valid;
    logic [BITWIDTH-1:0] r_out_data;
    logic                r_out_last;
    logic                r_frame_done;

    logic                w_accept;
    logic                w_handoff;
    logic                w_cx_last;
    logic                w_ry_last;
    logic                w_produce;
    logic                w_frame_end;
    logic [BITWIDTH-1:0] w_h;
    logic [BITWIDTH-1:0] w_lb;
    logic [BITWIDTH-1:0] w_win_max;

    // r_rdy_en keeps in_ready low while reset is asserted.
    assign bus.in_ready   = r_rdy_en && !bus.clear && (!r_out_valid || bus.out_ready);
    assign w_accept       = bus.in_valid && bus.in_ready;
    assign w_handoff      = r_out_valid && bus.out_ready;
    assign w_cx_last      = (r_cx == WIN_LAST);
    assign w_ry_last      = (r_ry == WIN_LAST);
    assign w_produce      = w_accept && w_cx_last && w_ry_last;
    assign w_frame_end    = (r_row == ROW_LAST) && (r_col == COL_LAST);

    // Running horizontal max including the current pixel; cx==0 starts a fresh window column.
    assign w_h       = (r_cx == '0) ? bus.in_data : umax(r_hmax, bus.in_data);
    assign w_lb      = r_lbuf[r_g];
    // Row 0 of a window seeds the line buffer; later rows fold in the stored partial max.
    assign w_win_max = (r_ry == '0) ? w_h : umax(w_lb, w_h);

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_last   = r_out_last;
    assign bus.frame_done = r_frame_done;

    // Advance raster position and window sub-counters on each accepted pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col    <= '0;
            r_row    <= '0;
            r_cx     <= '0;
            r_ry     <= '0;
            r_g      <= '0;
            r_hmax   <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (bus.clear) begin
                r_col  <= '0;
                r_row  <= '0;
                r_cx   <= '0;
                r_ry   <= '0;
                r_g    <= '0;
                r_hmax <= '0;
            end else if (w_accept) begin
                r_hmax <= w_h;
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_cx  <= '0;
                    r_g   <= '0;
                    r_ry  <= w_ry_last ? '0 : r_ry + PW'(1);
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                    if (w_cx_last) begin
                        r_cx <= '0;
                        r_g  <= r_g + GW'(1);
                    end else begin
                        r_cx <= r_cx + PW'(1);
                    end
                end
            end
        end
    end

    // Store the partial window max for every window row except the last; no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept && w_cx_last && !w_ry_last) begin
            r_lbuf[r_g] <= w_win_max;
        end
    end

    // Registered output stage: load on window completion, hold while stalled, drop after handoff.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (bus.clear) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_handoff && r_out_last;
            if (w_produce) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_win_max;
                r_out_last  <= w_frame_end;
            end else if (w_handoff) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_max_pool_ctrl.sv
// Randomized scoreboard bench for max_pool_ctrl: 4x4/POOL2 and 6x6/POOL3 instances.
// Latency: expected windows are queued at frame issue and popped on each output handoff.
// Backpressure: out_ready patterns cover always-ready, fixed 3-cycle stalls, random and hold-low.
module tb_max_pool_ctrl;
    logic clk;
    logic rstn;

    max_pool_ctrl_if #(.BITWIDTH(8)) a();
    max_pool_ctrl_if #(.BITWIDTH(8)) b();

    max_pool_ctrl #(.BITWIDTH(8), .IMG_W(4), .IMG_H(4), .POOL(2)) u_dut_a (
        .clk (clk),
        .rstn(rstn),
        .bus (a)
    );

    max_pool_ctrl #(.BITWIDTH(8), .IMG_W(6), .IMG_H(6), .POOL(3)) u_dut_b (
        .clk (clk),
        .rstn(rstn),
        .bus (b)
    );

    int checks;
    int errors;
    int mode_a;
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    // Reference: max over each non-overlapping p x p window, raster window order.
    function automatic void model(input int w, input int h, input int p, input int px[$], input bit sel);
        for (int wy = 0; wy < h / p; wy++) begin
            for (int wx = 0; wx < w / p; wx++) begin
                int m;
                logic [8:0] e;
                m = 0;
                for (int dy = 0; dy < p; dy++)
                    for (int dx = 0; dx < p; dx++)
                        if (px[(wy * p + dy) * w + wx * p + dx] > m) m = px[(wy * p + dy) * w + wx * p + dx];
                e = {(wy == h / p - 1) && (wx == w / p - 1), 8'(m)};
                if (sel) q_b.push_back(e);
                else     q_a.push_back(e);
            end
        end
    endfunction

    task automatic drive_a(input int px[$], input int n, input bit gaps);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                a.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            a.in_valid = 1'b1;
            a.in_data  = 8'(px[i]);
            w = 0;
            forever begin
                @(negedge clk);
                if (a.in_ready) break;
                w++;
                if (w > 300) begin
                    chk("a_in_ready_timeout", 0, 1);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        a.in_valid = 1'b0;
    endtask

    task automatic drive_b(input int px[$], input bit gaps);
        int w;
        for (int i = 0; i < px.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                b.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            b.in_valid = 1'b1;
            b.in_data  = 8'(px[i]);
            w = 0;
            forever begin
                @(negedge clk);
                if (b.in_ready) break;
                w++;
                if (w > 300) begin
                    chk("b_in_ready_timeout", 0, 1);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        b.in_valid = 1'b0;
    endtask

    task automatic drain(input bit sel);
        int n;
        n = 0;
        while (((sel ? q_b.size() : q_a.size()) != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (sel) chk("b_drain_left", q_b.size(), 0);
        else     chk("a_drain_left", q_a.size(), 0);
    endtask

    task automatic rand_frame(output int px[$], input int n, input int lo, input int hi);
        px = {};
        for (int i = 0; i < n; i++) px.push_back(int'($urandom_range(lo, hi)));
    endtask

    // out_ready pattern generator for instance A
    initial begin : rdy_gen_a
        int st;
        bit ovd;
        st  = 0;
        ovd = 1'b0;
        a.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mode_a)
                0: a.out_ready = 1'b1;
                1: begin
                    if (a.out_valid && !ovd) st = 3;
                    if (st > 0) begin
                        a.out_ready = 1'b0;
                        st--;
                    end else begin
                        a.out_ready = 1'b1;
                    end
                end
                2: a.out_ready = ($urandom_range(0, 2) != 0);
                default: a.out_ready = 1'b0;
            endcase
            ovd = a.out_valid;
        end
    end

    initial begin : rdy_gen_b
        b.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            b.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor A: scoreboard pop, hold stability, stall blocks input, frame_done pulse.
    initial begin : mon_a
        bit pa_stall, pa_clear, pa_hand_last, pa_last;
        logic [7:0] pa_data;
        logic [8:0] e;
        pa_stall = 0; pa_clear = 0; pa_hand_last = 0; pa_last = 0; pa_data = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pa_stall = 0; pa_clear = 0; pa_hand_last = 0;
            end else begin
                if (pa_hand_last || a.frame_done) chk("a_frame_done", int'(a.frame_done), int'(pa_hand_last));
                if (pa_stall && !pa_clear) begin
                    chk("a_hold_valid", int'(a.out_valid), 1);
                    chk("a_hold_data", int'(a.out_data), int'(pa_data));
                    chk("a_hold_last", int'(a.out_last), int'(pa_last));
                end
                if (a.out_valid && !a.out_ready) chk("a_stall_in_ready", int'(a.in_ready), 0);
                pa_hand_last = 0;
                if (a.out_valid && a.out_ready && !a.clear) begin
                    if (q_a.size() == 0) begin
                        chk("a_unexpected_output", int'(a.out_data), -1);
                    end else begin
                        e = q_a.pop_front();
                        chk("a_out_data", int'(a.out_data), int'(e[7:0]));
                        chk("a_out_last", int'(a.out_last), int'(e[8]));
                    end
                    pa_hand_last = a.out_last;
                end
                pa_stall = a.out_valid && !a.out_ready;
                pa_data  = a.out_data;
                pa_last  = a.out_last;
                pa_clear = a.clear;
            end
        end
    end

    initial begin : mon_b
        bit pb_hand_last;
        logic [8:0] e;
        pb_hand_last = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pb_hand_last = 0;
            end else begin
                if (pb_hand_last || b.frame_done) chk("b_frame_done", int'(b.frame_done), int'(pb_hand_last));
                pb_hand_last = 0;
                if (b.out_valid && b.out_ready) begin
                    if (q_b.size() == 0) begin
                        chk("b_unexpected_output", int'(b.out_data), -1);
                    end else begin
                        e = q_b.pop_front();
                        chk("b_out_data", int'(b.out_data), int'(e[7:0]));
                        chk("b_out_last", int'(b.out_last), int'(e[8]));
                    end
                    pb_hand_last = b.out_last;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int fr[$];
        int nf[$];
        checks = 0;
        errors = 0;
        mode_a = 0;
        rstn = 1'b0;
        a.clear = 1'b0; a.in_valid = 1'b0; a.in_data = '0;
        b.clear = 1'b0; b.in_valid = 1'b0; b.in_data = '0;
        #3;
        chk("rst_in_ready", int'(a.in_ready), 0);
        chk("rst_out_valid", int'(a.out_valid), 0);
        chk("rst_out_data", int'(a.out_data), 0);
        chk("rst_out_last", int'(a.out_last), 0);
        chk("rst_frame_done", int'(a.frame_done), 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", int'(a.in_ready), 1);
        @(posedge clk); #1;

        // Basic pooling, always ready
        fr = '{1, 5, 2, 0, 3, 4, 9, 8, 7, 7, 0, 0, 6, 2, 1, 255};
        model(4, 4, 2, fr, 0);
        drive_a(fr, 16, 0);
        drain(0);

        // Same frame with 3-cycle stalls after every output
        mode_a = 1;
        model(4, 4, 2, fr, 0);
        drive_a(fr, 16, 0);
        drain(0);

        // Extremes back to back
        mode_a = 0;
        fr = {};
        for (int i = 0; i < 16; i++) fr.push_back(0);
        model(4, 4, 2, fr, 0);
        drive_a(fr, 16, 0);
        fr = {};
        for (int i = 0; i < 16; i++) fr.push_back(255);
        model(4, 4, 2, fr, 0);
        drive_a(fr, 16, 0);
        drain(0);

        // Random frames, random ready, input gaps, narrow range for ties
        mode_a = 2;
        for (int k = 0; k < 8; k++) begin
            rand_frame(fr, 16, 0, (k % 2 == 0) ? 3 : 255);
            model(4, 4, 2, fr, 0);
            drive_a(fr, 16, 1);
        end
        drain(0);

        // Soft clear mid-frame: with a pending held output, and with input otherwise acceptable
        for (int t = 0; t < 2; t++) begin
            mode_a = (t == 0) ? 3 : 0;
            @(posedge clk); #1;
            rand_frame(fr, 16, 1, 255);
            drive_a(fr, (t == 0) ? 6 : 3, 0);
            a.clear = 1'b1; a.in_valid = 1'b1; a.in_data = 8'd200;
            @(negedge clk);
            chk("clear_in_ready", int'(a.in_ready), 0);
            @(posedge clk); #1;
            a.clear = 1'b0; a.in_valid = 1'b0;
            @(negedge clk);
            chk("clear_out_valid", int'(a.out_valid), 0);
            chk("clear_out_last", int'(a.out_last), 0);
            @(posedge clk); #1;
            mode_a = 0;
            rand_frame(nf, 16, 0, 255);
            model(4, 4, 2, nf, 0);
            drive_a(nf, 16, 0);
            drain(0);
        end

        // Async reset between edges while an output is held
        mode_a = 3;
        @(posedge clk); #1;
        rand_frame(fr, 16, 1, 255);
        drive_a(fr, 6, 0);
        chk("arst_pre_valid", int'(a.out_valid), 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_valid", int'(a.out_valid), 0);
        chk("arst_out_data", int'(a.out_data), 0);
        chk("arst_out_last", int'(a.out_last), 0);
        chk("arst_in_ready", int'(a.in_ready), 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        mode_a = 0;
        @(posedge clk); #1;
        rand_frame(fr, 16, 0, 255);
        model(4, 4, 2, fr, 0);
        drive_a(fr, 16, 1);
        drain(0);

        // POOL=3 on 6x6: ramp, then random frames
        fr = {};
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) fr.push_back(r * 6 + c);
        model(6, 6, 3, fr, 1);
        drive_b(fr, 0);
        for (int k = 0; k < 3; k++) begin
            rand_frame(fr, 36, 0, 255);
            model(6, 6, 3, fr, 1);
            drive_b(fr, 1);
        end
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
